sdc_cmd_sequencer: RTL and testbench
====================================

# sdc_cmd_sequencer

- Wishbone master that issues one SD command through the `sdc_controller` register port and returns its status and short response.
- Sequence per command: write argument and command registers, poll the command event status, read the response, clear status.
- Sits between the card-init/block-read FSMs and the `sdc_controller` slave port, replacing hand-coded register pokes with a command/response handshake.

## Interface
Parameters:
- POLL_LIMIT, 16'hFFFF, max status reads per command before timeout (watchdog build only)

Ports:
- Clocking and reset: reset is asynchronous, active-high; the clock is wb_clk.
- wb_clk  in  1  clock, also the Wishbone clock
- reset  in  1  async active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_index  in  6  SD command index (CMDn)
- cmd_cfg  in  8  low byte of controller command register (resp type, CRC/index check, data bits)
- cmd_arg  in  32  command argument
- rsp_valid  out  1  one-cycle pulse: command finished
- rsp_status  out  5  command event status bits [4:0] from the final poll
- rsp_data  out  32  RESPONSE_0 word
- rsp_timeout  out  1  poll limit reached; valid with rsp_valid
- busy  out  1  not IDLE
- wbm_adr_o  out  8  register address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_sel_o  out  4  byte select, always 4'b1111 during a cycle
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_ack_i  in  1  slave acknowledge

## Operation
- Register addresses: ARGUMENT 8'h00, COMMAND 8'h04, RESPONSE_0 8'h08, CMD_EVENT_STATUS 8'h34.
- Status bits: bit0 = complete; bits[4:1] = error flags.
- Command word: {18'd0, cmd_index, cmd_cfg}.
- Handshake: cmd_index, cmd_cfg and cmd_arg are latched when cmd_valid && cmd_ready (IDLE only).
- Requests arriving while busy are ignored and cmd_ready stays low.
- States:
  - IDLE: cmd_ready = 1.
  - WR_ARG: write cmd_arg to ARGUMENT.
  - WR_CMD: write command word to COMMAND; clear poll counter.
  - RD_STAT: read CMD_EVENT_STATUS.
    - If read data bit0 or any of bits[4:1] is set: latch rsp_status, go to RD_RESP.
    - Otherwise increment poll counter and repeat RD_STAT.
  - RD_RESP: read RESPONSE_0 into rsp_data. This is also done on error; the data is then undefined.
  - CLR_STAT: write 0 to CMD_EVENT_STATUS.
  - DONE: rsp_valid = 1 for one cycle, then IDLE.
- Bus access rules:
  - cyc/stb/we/adr/dat are registered and asserted the edge after entering the access state.
  - They are held stable until wbm_ack_i is sampled high.
  - They are deasserted on that edge and the FSM advances.
  - At least one idle cycle (stb low) separates accesses. No pipelined or burst cycles.
- Read data is captured on the edge where ack is sampled.
- rsp_status, rsp_data and rsp_timeout hold their values until the next command's DONE.
- There is no response backpressure; consumers must sample on the rsp_valid pulse.

## Timing
- Reset values (asynchronous, applied immediately):
  - FSM = IDLE; cmd_ready = 1; busy = 0; rsp_valid = 0.
  - rsp_status = 0; rsp_data = 0; rsp_timeout = 0.
  - wbm_cyc_o = wbm_stb_o = wbm_we_o = 0; wbm_adr_o = 0; wbm_dat_o = 0; wbm_sel_o = 0.
- Reset mid-command: the bus cycle is dropped at once and no rsp_valid is produced. The controller's state is the user's problem (re-run init).
- Per access: 1 strobe cycle + N wait cycles + 1 idle cycle.
- With a 1-cycle ack slave and completion on the first poll, rsp_valid is high on the 16th edge after the accept edge (5 accesses × 3 cycles + DONE).
- Each extra poll adds 3 cycles.
- Poll counter is 16 bits, saturates, and is never wrapped.
- An ack sampled while stb is low is ignored.

## Configuration
- SDC_CMD_SEQ_WATCHDOG_EN defined:
  - After POLL_LIMIT status reads with bits[4:0] all zero, go to RD_RESP → CLR_STAT → DONE.
  - rsp_timeout = 1; rsp_status = last read value (0).
- Not defined:
  - Polling is unbounded; rsp_timeout is tied 0; POLL_LIMIT is unused.

## Test plan
- Reset, then idle 5 cycles → cmd_ready = 1, all wbm_* = 0, rsp_valid never pulses.
- Command index 8, arg 32'h000001AA, cmd_cfg 8'h19; slave acks after 1 cycle, status 5'h01, RESPONSE_0 32'h000001AA:
  - Writes in order: 8'h00 ← 32'h1AA, 8'h04 ← 32'h0819, 8'h34 read, 8'h08 read, 8'h34 ← 0.
  - rsp_valid on edge 16 with rsp_status = 5'h01 and rsp_data = 32'h1AA.
- Status reads 0 three times, then 5'h01 → exactly 4 status reads; rsp_valid 9 cycles later than the previous case.
- Status returns 5'h03 (error) → RD_RESP and CLR_STAT still executed; rsp_status = 5'h03; rsp_timeout = 0.
- Watchdog build with POLL_LIMIT = 4 and status stuck at 0 → exactly 4 status reads, then rsp_valid with rsp_timeout = 1.
- Assert reset while stb is high during WR_CMD → cyc/stb low in the same cycle; after release, a new command completes normally; cmd_valid held high while busy is not re-accepted.

Source files
------------

// File: rtl/sdc_cmd_sequencer.sv
// Wishbone master that runs one SD command through the sdc_controller register port.
// Define SDC_CMD_SEQ_WATCHDOG_EN to bound status polling at POLL_LIMIT reads.
module sdc_cmd_sequencer #(
   parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
   input  logic        wb_clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [5:0]  cmd_index,
   input  logic [7:0]  cmd_cfg,
   input  logic [31:0] cmd_arg,
   output logic        rsp_valid,
   output logic [4:0]  rsp_status,
   output logic [31:0] rsp_data,
   output logic        rsp_timeout,
   output logic        busy,
   output logic [7:0]  wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i
);

   localparam logic [7:0] ADR_ARGUMENT   = 8'h00;
   localparam logic [7:0] ADR_COMMAND    = 8'h04;
   localparam logic [7:0] ADR_RESPONSE_0 = 8'h08;
   localparam logic [7:0] ADR_CMD_EVENT  = 8'h34;

   typedef enum logic [2:0] {
      IDLE, WR_ARG, WR_CMD, RD_STAT, RD_RESP, CLR_STAT, DONE
   } state_t;

   state_t      state, next_state;
   logic [5:0]  index_q;
   logic [7:0]  cfg_q;
   logic [31:0] arg_q;
   logic [15:0] poll_cnt;
   logic [4:0]  stat_q;
   logic [31:0] data_q;
   logic        timeout_q;
   logic        ack_hit, accept, poll_expired;
   logic        acc_req, acc_we;
   logic [7:0]  acc_adr;
   logic [31:0] acc_dat;

   assign ack_hit   = wbm_cyc_o & wbm_stb_o & wbm_ack_i;
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign rsp_valid = (state == DONE);
   assign accept    = cmd_valid & cmd_ready;

`ifdef SDC_CMD_SEQ_WATCHDOG_EN
   assign poll_expired = (({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_LIMIT});
`else
   logic unused_poll;
   assign poll_expired = 1'b0;
   assign unused_poll  = ^{POLL_LIMIT, poll_cnt};
`endif

   always_ff @(posedge wb_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (cmd_valid) next_state = WR_ARG;
         WR_ARG:   if (ack_hit) next_state = WR_CMD;
         WR_CMD:   if (ack_hit) next_state = RD_STAT;
         RD_STAT:  if (ack_hit && ((wbm_dat_i[4:0] != 5'd0) || poll_expired)) next_state = RD_RESP;
         RD_RESP:  if (ack_hit) next_state = CLR_STAT;
         CLR_STAT: if (ack_hit) next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Which register access the current state wants on the bus
   always_comb begin
      acc_req = 1'b1;
      acc_we  = 1'b0;
      acc_adr = 8'h00;
      acc_dat = 32'd0;
      case (state)
         WR_ARG:   begin acc_we = 1'b1; acc_adr = ADR_ARGUMENT; acc_dat = arg_q; end
         WR_CMD:   begin acc_we = 1'b1; acc_adr = ADR_COMMAND; acc_dat = {18'd0, index_q, cfg_q}; end
         RD_STAT:  acc_adr = ADR_CMD_EVENT;
         RD_RESP:  acc_adr = ADR_RESPONSE_0;
         CLR_STAT: begin acc_we = 1'b1; acc_adr = ADR_CMD_EVENT; end
         default:  acc_req = 1'b0;
      endcase
   end

   // Bus signals start one edge after an idle cycle and drop on the ack edge
   always_ff @(posedge wb_clk or posedge reset) begin
      if (reset) begin
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'b0000;
         wbm_adr_o <= 8'h00;
         wbm_dat_o <= 32'd0;
      end else if (wbm_cyc_o) begin
         if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'b0000;
            wbm_adr_o <= 8'h00;
            wbm_dat_o <= 32'd0;
         end
      end else if (acc_req) begin
         wbm_cyc_o <= 1'b1;
         wbm_stb_o <= 1'b1;
         wbm_we_o  <= acc_we;
         wbm_sel_o <= 4'b1111;
         wbm_adr_o <= acc_adr;
         wbm_dat_o <= acc_dat;
      end
   end

   // Command latch, poll bookkeeping, and response registers published at DONE
   always_ff @(posedge wb_clk or posedge reset) begin
      if (reset) begin
         index_q     <= 6'd0;
         cfg_q       <= 8'd0;
         arg_q       <= 32'd0;
         poll_cnt    <= 16'd0;
         stat_q      <= 5'd0;
         data_q      <= 32'd0;
         timeout_q   <= 1'b0;
         rsp_status  <= 5'd0;
         rsp_data    <= 32'd0;
         rsp_timeout <= 1'b0;
      end else begin
         if (accept) begin
            index_q   <= cmd_index;
            cfg_q     <= cmd_cfg;
            arg_q     <= cmd_arg;
            timeout_q <= 1'b0;
         end
         if (state == WR_CMD) poll_cnt <= 16'd0;
         if (state == RD_STAT && ack_hit) begin
            stat_q <= wbm_dat_i[4:0];
            if (wbm_dat_i[4:0] == 5'd0) begin
               if (poll_cnt != 16'hFFFF) poll_cnt <= poll_cnt + 16'd1;
               if (poll_expired) timeout_q <= 1'b1;
            end
         end
         if (state == RD_RESP && ack_hit) data_q <= wbm_dat_i;
         if (state == CLR_STAT && ack_hit) begin
            rsp_status  <= stat_q;
            rsp_data    <= data_q;
            rsp_timeout <= timeout_q;
         end
      end
   end

endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// Directed bench for sdc_cmd_sequencer with a registered-ack register-port slave model.
module tb_sdc_cmd_sequencer;

   logic        wb_clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready;
   logic [5:0]  cmd_index;
   logic [7:0]  cmd_cfg;
   logic [31:0] cmd_arg;
   logic        rsp_valid, rsp_timeout, busy;
   logic [4:0]  rsp_status;
   logic [31:0] rsp_data;
   logic [7:0]  wbm_adr_o;
   logic [31:0] wbm_dat_o, wbm_dat_i;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  log_adr[$];
   logic        log_we[$];
   logic [31:0] log_dat[$];
   logic [3:0]  log_sel[$];
   logic [4:0]  stat_seq[$];
   logic [4:0]  stat_now;
   logic [31:0] resp_word;
   int          stat_reads;

   sdc_cmd_sequencer #(.POLL_LIMIT(16'd4)) dut (
      .wb_clk(wb_clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_index(cmd_index), .cmd_cfg(cmd_cfg), .cmd_arg(cmd_arg),
      .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout), .busy(busy),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i)
   );

   always #5 wb_clk = ~wb_clk;

   // Slave acks one cycle after seeing a strobe; the last status value is sticky
   always @(posedge wb_clk or posedge reset) begin
      if (reset) begin
         wbm_ack_i <= 1'b0;
         wbm_dat_i <= 32'd0;
      end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
         wbm_ack_i <= 1'b1;
         log_adr.push_back(wbm_adr_o);
         log_we.push_back(wbm_we_o);
         log_dat.push_back(wbm_dat_o);
         log_sel.push_back(wbm_sel_o);
         if (!wbm_we_o && wbm_adr_o == 8'h34) begin
            stat_reads++;
            if (stat_seq.size() > 1)       stat_now = stat_seq.pop_front();
            else if (stat_seq.size() == 1) stat_now = stat_seq[0];
            else                           stat_now = 5'd0;
            wbm_dat_i <= {27'd0, stat_now};
         end else if (!wbm_we_o && wbm_adr_o == 8'h08) begin
            wbm_dat_i <= resp_word;
         end else begin
            wbm_dat_i <= 32'd0;
         end
      end else begin
         wbm_ack_i <= 1'b0;
      end
   end

   task automatic run_cmd(input logic [5:0] idx, input logic [7:0] cfg, input logic [31:0] arg,
                          input bit hold, output int lat, output bit done, output int ready_hi);
      bit seen;
      log_adr.delete(); log_we.delete(); log_dat.delete(); log_sel.delete();
      stat_reads = 0;
      lat = 0; done = 1'b0; ready_hi = 0;
      @(negedge wb_clk);
      cmd_index = idx; cmd_cfg = cfg; cmd_arg = arg; cmd_valid = 1'b1;
      @(posedge wb_clk);
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge wb_clk);
         if (!hold) cmd_valid = 1'b0;
         if (hold) cmd_arg = ~arg;
         if (cmd_ready) ready_hi++;
         seen = rsp_valid;
         if (seen) cmd_valid = 1'b0;
         @(posedge wb_clk);
         lat++;
         if (seen) done = 1'b1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cmd_valid = 1'b0; cmd_index = 6'd0; cmd_cfg = 8'd0; cmd_arg = 32'd0;
      resp_word = 32'd0;
      repeat (3) @(posedge wb_clk);
      @(negedge wb_clk); reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge wb_clk);
         n_checks++;
         if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 ||
             {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== 47'd0) begin
            n_fail++;
            $display("[TB] FAIL idle_cycle%0d: ready=%b busy=%b rsp_valid=%b cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h, expected ready=1 and all else 0",
                     i, cmd_ready, busy, rsp_valid, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o);
         end
      end
      n_checks++;
      if ({rsp_status, rsp_data, rsp_timeout} !== 38'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_rsp: status=%h data=%h timeout=%b, expected all 0", rsp_status, rsp_data, rsp_timeout);
      end
   endtask

   task automatic test_basic();
      int lat, rdy; bit done;
      logic [7:0]  e_adr [5] = '{8'h00, 8'h04, 8'h34, 8'h08, 8'h34};
      logic        e_we  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] e_dat [5] = '{32'h1AA, 32'h0819, 32'h0, 32'h0, 32'h0};
      stat_seq = '{5'h01};
      resp_word = 32'h000001AA;
      run_cmd(6'd8, 8'h19, 32'h000001AA, 1'b0, lat, done, rdy);
      n_checks++;
      if (!done || lat != 16) begin
         n_fail++;
         $display("[TB] FAIL basic_latency: done=%b edges=%0d, expected done=1 edges=16", done, lat);
      end
      n_checks++;
      if (log_adr.size() != 5) begin
         n_fail++;
         $display("[TB] FAIL basic_access_count: got %0d, expected 5", log_adr.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (log_adr[i] !== e_adr[i] || log_we[i] !== e_we[i] || log_sel[i] !== 4'hF ||
                (e_we[i] && log_dat[i] !== e_dat[i])) begin
               n_fail++;
               $display("[TB] FAIL basic_access%0d: adr=%h we=%b sel=%h dat=%h, expected adr=%h we=%b sel=f dat=%h",
                        i, log_adr[i], log_we[i], log_sel[i], log_dat[i], e_adr[i], e_we[i], e_dat[i]);
            end
         end
      end
      n_checks++;
      if (rsp_status !== 5'h01 || rsp_data !== 32'h1AA || rsp_timeout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_rsp: status=%h data=%h timeout=%b, expected 01 000001aa 0", rsp_status, rsp_data, rsp_timeout);
      end
      @(negedge wb_clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_pulse_width: rsp_valid=%b ready=%b, expected 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_polling();
      int lat, rdy; bit done;
      stat_seq = '{5'h00, 5'h00, 5'h00, 5'h01};
      resp_word = 32'hCAFE0001;
      run_cmd(6'd17, 8'h1A, 32'h00000200, 1'b0, lat, done, rdy);
      n_checks++;
      if (!done || lat != 25) begin
         n_fail++;
         $display("[TB] FAIL poll_latency: done=%b edges=%0d, expected done=1 edges=25", done, lat);
      end
      n_checks++;
      if (stat_reads != 4 || log_adr.size() != 8) begin
         n_fail++;
         $display("[TB] FAIL poll_reads: status reads=%0d accesses=%0d, expected 4 and 8", stat_reads, log_adr.size());
      end
      n_checks++;
      if (rsp_status !== 5'h01 || rsp_data !== 32'hCAFE0001) begin
         n_fail++;
         $display("[TB] FAIL poll_rsp: status=%h data=%h, expected 01 cafe0001", rsp_status, rsp_data);
      end
   endtask

   task automatic test_error();
      int lat, rdy; bit done;
      stat_seq = '{5'h03};
      resp_word = 32'hDEADBEEF;
      run_cmd(6'd55, 8'h11, 32'h0, 1'b0, lat, done, rdy);
      n_checks++;
      if (!done || lat != 16) begin
         n_fail++;
         $display("[TB] FAIL err_latency: done=%b edges=%0d, expected done=1 edges=16", done, lat);
      end
      n_checks++;
      if (log_adr.size() != 5 || log_adr[3] !== 8'h08 || log_we[4] !== 1'b1 || log_adr[4] !== 8'h34) begin
         n_fail++;
         $display("[TB] FAIL err_sequence: accesses=%0d, expected RESPONSE_0 read and status clear as accesses 4 and 5", log_adr.size());
      end
      n_checks++;
      if (rsp_status !== 5'h03 || rsp_timeout !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL err_rsp: status=%h timeout=%b, expected 03 0", rsp_status, rsp_timeout);
      end
   endtask

`ifdef SDC_CMD_SEQ_WATCHDOG_EN
   task automatic test_watchdog();
      int lat, rdy; bit done;
      stat_seq = '{5'h00};
      resp_word = 32'h12345678;
      run_cmd(6'd8, 8'h19, 32'h1AA, 1'b0, lat, done, rdy);
      n_checks++;
      if (!done || lat != 25 || stat_reads != 4) begin
         n_fail++;
         $display("[TB] FAIL wdog_reads: done=%b edges=%0d reads=%0d, expected 1 25 4", done, lat, stat_reads);
      end
      n_checks++;
      if (rsp_timeout !== 1'b1 || rsp_status !== 5'h00) begin
         n_fail++;
         $display("[TB] FAIL wdog_rsp: timeout=%b status=%h, expected 1 00", rsp_timeout, rsp_status);
      end
   endtask
`endif

   task automatic test_back_to_back();
      int lat, rdy; bit found, done;
      stat_seq = '{5'h01};
      resp_word = 32'h00000900;
      found = 1'b0;
      @(negedge wb_clk);
      cmd_index = 6'd2; cmd_cfg = 8'h29; cmd_arg = 32'h0; cmd_valid = 1'b1;
      @(negedge wb_clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (wbm_stb_o && wbm_adr_o == 8'h04) found = 1'b1;
         else @(negedge wb_clk);
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("[TB] FAIL rst_find_wrcmd: COMMAND strobe seen=%b, expected 1", found);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rst_midcmd: cyc=%b stb=%b busy=%b ready=%b, expected 0 0 0 1", wbm_cyc_o, wbm_stb_o, busy, cmd_ready);
      end
      repeat (2) @(negedge wb_clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_status !== 5'd0 || rsp_data !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL rst_hold: rsp_valid=%b status=%h data=%h, expected 0 00 0", rsp_valid, rsp_status, rsp_data);
      end
      reset = 1'b0;
      run_cmd(6'd9, 8'h1B, 32'h00050000, 1'b1, lat, done, rdy);
      n_checks++;
      if (!done || lat != 16 || rdy != 0) begin
         n_fail++;
         $display("[TB] FAIL b2b_run: done=%b edges=%0d ready_while_busy=%0d, expected 1 16 0", done, lat, rdy);
      end
      n_checks++;
      if (log_adr.size() != 5 || log_dat[0] !== 32'h00050000 || log_dat[1] !== 32'h0000091B) begin
         n_fail++;
         $display("[TB] FAIL b2b_latched: accesses=%0d arg=%h cmd=%h, expected 5 00050000 0000091b",
                  log_adr.size(), log_dat[0], log_dat[1]);
      end
      repeat (4) @(negedge wb_clk);
      n_checks++;
      if (busy !== 1'b0 || log_adr.size() != 5) begin
         n_fail++;
         $display("[TB] FAIL b2b_no_reaccept: busy=%b accesses=%0d, expected 0 5", busy, log_adr.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_polling();
      test_error();
`ifdef SDC_CMD_SEQ_WATCHDOG_EN
      test_watchdog();
`endif
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
